// File: rtl/aes_access_unit.sv
// Bus sequencer for AES accelerator accesses issued from the execute stage.
// It moves 1, 4 or 8 words per op over a simple req/ack bus and reports done/err.
module aes_access_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [2:0]   op_i,
    input  logic [31:0]  base_addr_i,
    input  logic         key256_i,
    input  logic [255:0] wdata_i,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [31:0]  mem_wdata_o,
    input  logic         mem_ack_i,
    input  logic [31:0]  mem_rdata_i,
    output logic         stall_o,
    output logic         done_o,
    output logic         err_o,
    output logic [127:0] result_o
);

    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(ACK_TIMEOUT);

    localparam logic [2:0] OP_KEY    = 3'd1;
    localparam logic [2:0] OP_CTRL   = 3'd2;
    localparam logic [2:0] OP_CONFIG = 3'd3;
    localparam logic [2:0] OP_RESULT = 3'd4;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [31:0]    base_q, base_d;
    logic           key256_q, key256_d;
    logic [255:0]   wdata_q, wdata_d;
    logic [3:0]     idx_q, idx_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
    logic [127:0]   result_q, result_d;

    logic [3:0]     numWords;
    logic           lastWord;
    logic           isRead;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            base_q   <= '0;
            key256_q <= 1'b0;
            wdata_q  <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            base_q   <= base_d;
            key256_q <= key256_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        base_d   = base_q;
        key256_d = key256_q;
        wdata_d  = wdata_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        result_d = result_q;

        case (op_q)
            OP_KEY:               numWords = key256_q ? 4'd8 : 4'd4;
            OP_CTRL, OP_CONFIG:   numWords = 4'd1;
            default:              numWords = 4'd4;
        endcase
        lastWord = (idx_q == numWords - 4'd1);
        isRead   = (op_q == OP_RESULT);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d     = op_i;
                    base_d   = base_addr_i;
                    key256_d = key256_i;
                    wdata_d  = wdata_i;
                    idx_d    = '0;
                    tmo_d    = '0;
                    if (op_i <= OP_RESULT) begin
                        state_d = XFER;
                        err_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            XFER: begin
                // An ack on the final timeout cycle still counts as a completed word.
                if (mem_ack_i) begin
                    if (isRead) begin
                        result_d[{idx_q[1:0], 5'b0} +: 32] = mem_rdata_i;
                    end
                    idx_d = idx_q + 4'd1;
                    tmo_d = '0;
                    if (lastWord) begin
                        state_d = DONE;
                        err_d   = 1'b0;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q + 1'b1 == TMO_LIM) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_o   = (state_q == XFER);
    assign mem_we_o    = (state_q == XFER) && !isRead;
    assign mem_addr_o  = (state_q == XFER) ? base_q + {26'b0, idx_q, 2'b00} : 32'h0;
    assign mem_wdata_o = mem_we_o ? wdata_q[{idx_q[2:0], 5'b0} +: 32] : 32'h0;
    assign stall_o     = (state_q == XFER) || ((state_q == IDLE) && start_i);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == DONE) && err_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_aes_access_unit.sv
// Scoreboard bench for aes_access_unit: stimulus pushes expected bus words and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_aes_access_unit;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [2:0]   op_i;
    logic [31:0]  base_addr_i;
    logic         key256_i;
    logic [255:0] wdata_i;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic         mem_ack_i = 1'b0;
    logic [31:0]  mem_rdata_i = 32'h0;
    logic         stall_o;
    logic         done_o;
    logic         err_o;
    logic [127:0] result_o;

    always #5 clk = ~clk;

    aes_access_unit #(.ACK_TIMEOUT(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .base_addr_i (base_addr_i),
        .key256_i    (key256_i),
        .wdata_i     (wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .result_o    (result_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic         err;
        int           lat;
        int           reqs;
        logic [127:0] result;
    } done_t;

    xfer_t        xferQ[$];
    done_t        doneQ[$];
    logic [31:0]  rdQ[$];
    int           testsRun = 0;
    int           testsFailed = 0;
    int           cyc = 0;
    int           startCyc = 0;
    int           reqCnt = 0;
    int           doneCnt = 0;
    int           doneTarget = 0;
    int           ackWait = 0;
    int           ackLeft = -1;
    int           waitCnt = 0;
    logic [127:0] expResult = '0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void pushX(input logic we, input logic [31:0] addr, input logic [31:0] data);
        xfer_t x;
        x.we = we; x.addr = addr; x.data = data;
        xferQ.push_back(x);
    endfunction

    function automatic void pushDone(input logic err, input int lat, input int reqs);
        done_t d;
        d.err = err; d.lat = lat; d.reqs = reqs; d.result = expResult;
        doneQ.push_back(d);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: acks after ackWait idle cycles, optionally stops acking,
    // and drives spurious acks whenever no request is pending.
    always @(posedge clk) begin
        #2;
        if (mem_req_o === 1'b1) begin
            if (ackLeft != 0 && waitCnt == ackWait) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = 32'h0;
                if (rdQ.size() > 0) mem_rdata_i = rdQ.pop_front();
                if (ackLeft > 0) ackLeft--;
                waitCnt = 0;
            end else begin
                mem_ack_i = 1'b0;
                mem_rdata_i = 32'h0;
                waitCnt++;
            end
        end else begin
            mem_ack_i = 1'b1;
            mem_rdata_i = 32'hDEAD_BEEF;
            waitCnt = 0;
        end
    end

    always @(negedge clk) begin
        if (mem_req_o === 1'b1) begin
            reqCnt++;
            check("stall_in_xfer", 128'(stall_o), 128'(1));
        end
        if (mem_req_o === 1'b1 && mem_ack_i === 1'b1) begin
            if (xferQ.size() == 0) begin
                testsRun++; testsFailed++;
                $display("[TB] FAIL unexpected_xfer: got addr %0h, required no transfer", mem_addr_o);
            end else begin
                xfer_t x;
                x = xferQ.pop_front();
                check("xfer_we",    128'(mem_we_o),    128'(x.we));
                check("xfer_addr",  128'(mem_addr_o),  128'(x.addr));
                check("xfer_wdata", 128'(mem_wdata_o), 128'(x.data));
            end
        end
        if (done_o === 1'b1) begin
            doneCnt++;
            if (doneQ.size() == 0) begin
                testsRun++; testsFailed++;
                $display("[TB] FAIL unexpected_done: got done_o=1, required 0");
            end else begin
                done_t d;
                d = doneQ.pop_front();
                check("done_err",     128'(err_o),          128'(d.err));
                check("done_latency", 128'(cyc - startCyc), 128'(d.lat));
                check("req_cycles",   128'(reqCnt),         128'(d.reqs));
                check("result",       result_o,             d.result);
                check("stall_in_done", 128'(stall_o),       128'(0));
            end
            reqCnt = 0;
        end else if (err_o === 1'b1) begin
            testsRun++; testsFailed++;
            $display("[TB] FAIL err_without_done: got err_o=1, required 0");
        end
        if (rst_i === 1'b1) reqCnt = 0;
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] base, input logic k256,
                                 input logic [255:0] wd, input int wt, input int acks);
        @(posedge clk);
        #1;
        ackWait = wt;
        ackLeft = acks;
        waitCnt = 0;
        doneTarget = doneCnt + 1;
        start_i = 1'b1;
        op_i = op;
        base_addr_i = base;
        key256_i = k256;
        wdata_i = wd;
        @(negedge clk);
        startCyc = cyc;
        check("stall_on_start", 128'(stall_o), 128'(1));
        @(posedge clk);
        #1;
        start_i = 1'b0;
        base_addr_i = ~base;
        wdata_i = ~wd;
        key256_i = ~k256;
    endtask

    task automatic checkOutput(input string name);
        int budget = 100;
        while (doneCnt < doneTarget && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        testsRun++;
        if (doneCnt < doneTarget) begin
            testsFailed++;
            $display("[TB] FAIL %s_timeout: got no done_o within 100 cycles, required done_o", name);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] wd;
        rst_i = 1'b1;
        start_i = 1'b0;
        op_i = 3'd0;
        base_addr_i = 32'h0;
        key256_i = 1'b0;
        wdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req",    128'(mem_req_o),   128'(0));
        check("rst_we",     128'(mem_we_o),    128'(0));
        check("rst_addr",   128'(mem_addr_o),  128'(0));
        check("rst_wdata",  128'(mem_wdata_o), 128'(0));
        check("rst_stall",  128'(stall_o),     128'(0));
        check("rst_done",   128'(done_o),      128'(0));
        check("rst_err",    128'(err_o),       128'(0));
        check("rst_result", result_o,          128'(0));
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // BLOCK write, ack every cycle
        wd = {128'h0, 32'h44, 32'h33, 32'h22, 32'h11};
        pushX(1'b1, 32'h4000_0010, 32'h11);
        pushX(1'b1, 32'h4000_0014, 32'h22);
        pushX(1'b1, 32'h4000_0018, 32'h33);
        pushX(1'b1, 32'h4000_001C, 32'h44);
        pushDone(1'b0, 5, 4);
        applyStimulus(3'd0, 32'h4000_0010, 1'b0, wd, 0, -1);
        checkOutput("block");

        // RESULT read with two wait cycles per word
        rdQ = '{32'hA, 32'hB, 32'hC, 32'hD};
        pushX(1'b0, 32'h4000_0040, 32'h0);
        pushX(1'b0, 32'h4000_0044, 32'h0);
        pushX(1'b0, 32'h4000_0048, 32'h0);
        pushX(1'b0, 32'h4000_004C, 32'h0);
        expResult = 128'h0000000D_0000000C_0000000B_0000000A;
        pushDone(1'b0, 13, 12);
        applyStimulus(3'd4, 32'h4000_0040, 1'b0, {256{1'b1}}, 2, -1);
        checkOutput("result");

        // 256-bit KEY write wrapping past the top of the address space
        for (int i = 0; i < 8; i++) wd[32*i +: 32] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 8; i++) pushX(1'b1, 32'hFFFF_FFF0 + 32'(4 * i), 32'h1000_0000 + 32'(i));
        pushDone(1'b0, 9, 8);
        applyStimulus(3'd1, 32'hFFFF_FFF0, 1'b1, wd, 0, -1);
        checkOutput("key256");

        // 128-bit KEY write
        for (int i = 0; i < 4; i++) pushX(1'b1, 32'h0000_0100 + 32'(4 * i), 32'h1000_0000 + 32'(i));
        pushDone(1'b0, 5, 4);
        applyStimulus(3'd1, 32'h0000_0100, 1'b0, wd, 0, -1);
        checkOutput("key128");

        // CTRL and CONFIG single-word writes
        pushX(1'b1, 32'h0000_0200, 32'h0000_C0DE);
        pushDone(1'b0, 2, 1);
        applyStimulus(3'd2, 32'h0000_0200, 1'b0, {224'h0, 32'h0000_C0DE}, 0, -1);
        checkOutput("ctrl");
        pushX(1'b1, 32'h0000_0300, 32'h0000_00CF);
        pushDone(1'b0, 3, 2);
        applyStimulus(3'd3, 32'h0000_0300, 1'b0, {224'h0, 32'h0000_00CF}, 1, -1);
        checkOutput("config");

        // Illegal op codes
        pushDone(1'b1, 1, 0);
        applyStimulus(3'd6, 32'h0000_0400, 1'b0, wd, 0, -1);
        checkOutput("illegal6");
        pushDone(1'b1, 1, 0);
        applyStimulus(3'd7, 32'h0000_0400, 1'b0, wd, 0, -1);
        checkOutput("illegal7");

        // No ack at all: request held four cycles then abort
        pushDone(1'b1, 5, 4);
        applyStimulus(3'd0, 32'h0000_0600, 1'b0, wd, 0, 0);
        checkOutput("timeout");

        // RESULT read that times out after two words keeps the partial update
        rdQ = '{32'h55, 32'h66};
        pushX(1'b0, 32'h0000_0080, 32'h0);
        pushX(1'b0, 32'h0000_0084, 32'h0);
        expResult = 128'h0000000D_0000000C_00000066_00000055;
        pushDone(1'b1, 7, 6);
        applyStimulus(3'd4, 32'h0000_0080, 1'b0, wd, 0, 2);
        checkOutput("partial");

        // start_i during XFER must be ignored
        wd = {128'h0, 32'hD4, 32'hC3, 32'hB2, 32'hA1};
        pushX(1'b1, 32'h0000_0700, 32'hA1);
        pushX(1'b1, 32'h0000_0704, 32'hB2);
        pushX(1'b1, 32'h0000_0708, 32'hC3);
        pushX(1'b1, 32'h0000_070C, 32'hD4);
        pushDone(1'b0, 13, 12);
        applyStimulus(3'd0, 32'h0000_0700, 1'b0, wd, 2, -1);
        start_i = 1'b1;
        op_i = 3'd7;
        repeat (2) @(posedge clk);
        #1;
        start_i = 1'b0;
        checkOutput("start_ignored");

        // Reset during the second word of a BLOCK write aborts silently
        wd = {128'h0, 32'h4, 32'h3, 32'h2, 32'h1};
        pushX(1'b1, 32'h0000_0500, 32'h1);
        pushX(1'b1, 32'h0000_0504, 32'h2);
        applyStimulus(3'd0, 32'h0000_0500, 1'b0, wd, 0, -1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("abort_req",    128'(mem_req_o), 128'(0));
        check("abort_stall",  128'(stall_o),   128'(0));
        check("abort_done",   128'(done_o),    128'(0));
        check("abort_result", result_o,        128'(0));
        expResult = '0;
        repeat (5) @(negedge clk);

        // Recovery after reset
        pushX(1'b1, 32'h0000_0900, 32'h0000_BEEF);
        pushDone(1'b0, 2, 1);
        applyStimulus(3'd2, 32'h0000_0900, 1'b0, {224'h0, 32'h0000_BEEF}, 0, -1);
        checkOutput("recover");

        repeat (3) @(negedge clk);
        check("xfer_queue_empty", 128'(xferQ.size()), 128'(0));
        check("done_queue_empty", 128'(doneQ.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/aes_access_unit.md
AES_ACCESS_UNIT -- requirements
Module: aes_access_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, max cycles to wait for mem_ack_i per word before aborting.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  request from execute stage to run one AES access op.
REQ-005 SHALL have port op_i  input  3  op code: 0 BLOCK write, 1 KEY write, 2 CTRL write, 3 CONFIG write, 4 RESULT read, 5-7 illegal.
REQ-006 SHALL have port base_addr_i  input  32  first word address (immediate produced for AES_*_TYPE selects).
REQ-007 SHALL have port key256_i  input  1  KEY op length: 1 = 8 words, 0 = 4 words.
REQ-008 SHALL have port wdata_i  input  256  write payload, word n = wdata_i[32n+31:32n].
REQ-009 SHALL have port mem_req_o  output  1  bus request valid.
REQ-010 SHALL have port mem_we_o  output  1  1 = write, 0 = read.
REQ-011 SHALL have port mem_addr_o  output  32  word address.
REQ-012 SHALL have port mem_wdata_o  output  32  write word.
REQ-013 SHALL have port mem_ack_i  input  1  bus completes current request this cycle.
REQ-014 SHALL have port mem_rdata_i  input  32  read data, valid with mem_ack_i.
REQ-015 SHALL have port stall_o  output  1  hold pipeline.
REQ-016 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-017 SHALL have port err_o  output  1  qualifies done_o: illegal op or timeout.
REQ-018 SHALL have port result_o  output  128  RESULT read data, word n = result_o[32n+31:32n].

Function
REQ-019 SHALL implement states IDLE, XFER, DONE.
REQ-020 IDLE: start_i=1 SHALL latch op_i, base_addr_i, key256_i, wdata_i, clear word index and timeout counter, go XFER (legal op) or DONE with err (illegal op).
REQ-021 Word count SHALL be: BLOCK 4, KEY 4 or 8 per key256_i, CTRL 1, CONFIG 1, RESULT 4.
REQ-022 XFER: mem_req_o=1; mem_addr_o = base + 4*index (32-bit wrap); mem_we_o=0 only for RESULT; mem_wdata_o = latched word[index], 0 for reads.
REQ-023 Request SHALL stay asserted with stable addr/we/wdata until mem_ack_i=1.
REQ-024 On ack in XFER: RESULT op SHALL write mem_rdata_i into result_o word[index]; index increments; timeout counter clears; last word -> DONE, else stay XFER and issue next word the following cycle without a gap.
REQ-025 mem_ack_i while mem_req_o=0 SHALL be ignored.
REQ-026 Timeout counter SHALL increment each XFER cycle without ack; reaching ACK_TIMEOUT SHALL drop mem_req_o next cycle and go DONE with err.
REQ-027 DONE: done_o=1 for exactly one cycle, err_o valid that cycle only, then IDLE; stall_o=0 in DONE.
REQ-028 stall_o SHALL be 1 in XFER and combinationally 1 in IDLE when start_i=1.
REQ-029 start_i in XFER or DONE SHALL be ignored; an op is accepted only in IDLE.
REQ-030 result_o SHALL hold its value between RESULT ops; partial update on timeout is retained.

Reset
REQ-031 rst_i=1 at a clock edge SHALL force IDLE and zero mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, done_o, err_o, result_o, index and timeout counter, overriding any in-flight op.
REQ-032 Reset SHALL take priority over start_i and mem_ack_i in the same cycle.

Verification
REQ-033 BLOCK op, base 0x4000_0010, wdata low words 0x11,0x22,0x33,0x44, ack every cycle -> writes to 0x10,0x14,0x18,0x1C in 4 consecutive cycles, done_o next cycle, err_o=0.
REQ-034 RESULT op, base 0x4000_0040, acks after 2-cycle waits returning 0xA,0xB,0xC,0xD -> result_o=0x0000000D_0000000C_0000000B_0000000A, stall_o high throughout XFER.
REQ-035 KEY op key256_i=1 -> exactly 8 writes, last to base+0x1C; key256_i=0 -> exactly 4.
REQ-036 op_i=6 -> no mem_req_o, done_o=1 with err_o=1 one cycle after start.
REQ-037 ACK_TIMEOUT=4, no ack -> mem_req_o high 4 cycles then low, done_o with err_o=1.
REQ-038 rst_i asserted during word 2 of BLOCK op -> next cycle mem_req_o=0, stall_o=0, state IDLE, no done_o.
